// File: rtl/stage_ex_mc_pkg.sv
// Shared constants for the multi-cycle execute stage:
// ALU opcodes, FSM encoding and the link register index.
package stage_ex_mc_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1100;
    localparam logic [3:0] OP_AND = 4'b0001;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1101;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_SRL = 4'b1110;
    localparam logic [3:0] OP_SRA = 4'b1010;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [4:0] RA = 5'd31;

    function automatic logic is_md(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/stage_ex_mc_if.sv
// ID/EX -> EX/MEM handshake bundle of the execute stage.
// master: pipeline neighbours; slave: the stage itself.
interface stage_ex_mc_if #(
    parameter int W = 32
);
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic         aluimm;
    logic         shift;
    logic         jal;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] imm;
    logic [W-1:0] pc4;
    logic [4:0]   rw_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ans;
    logic [4:0]   rw;
    logic         busy;

    modport master (
        output flush, in_valid, op, aluimm, shift, jal,
        output a, b, imm, pc4, rw_in, out_ready,
        input  in_ready, out_valid, ans, rw, busy
    );

    modport slave (
        input  flush, in_valid, op, aluimm, shift, jal,
        input  a, b, imm, pc4, rw_in, out_ready,
        output in_ready, out_valid, ans, rw, busy
    );

endinterface

// File: rtl/stage_ex_mc_mdu.sv
// Iterative multiply/divide: shift-add multiplier and restoring
// divider sharing one adder; done pulses W cycles after start.
module stage_ex_mc_mdu #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         kill,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] result
);
    localparam int CW = $clog2(W);

    logic          run;
    logic          div_q;
    logic [CW-1:0] count;
    logic [W-1:0]  acc;
    logic [W-1:0]  mq;
    logic [W-1:0]  opd;
    logic [W-1:0]  addend;
    logic [W:0]    x;
    logic [W:0]    y;
    logic [W:0]    sum;
    logic          cin;

    // div: trial subtract of divisor from {rem, next dividend bit}
    always_comb begin
        addend = mq[0] ? opd : '0;
        x      = {1'b0, acc};
        y      = {1'b0, addend};
        cin    = 1'b0;
        if (div_q) begin
            x   = {acc, mq[W-1]};
            y   = ~{1'b0, opd};
            cin = 1'b1;
        end
        sum = x + y + {{W{1'b0}}, cin};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run   <= 1'b0;
            div_q <= 1'b0;
            count <= '0;
            acc   <= '0;
            mq    <= '0;
            opd   <= '0;
            done  <= 1'b0;
        end else if (kill) begin
            run   <= 1'b0;
            count <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                run   <= 1'b1;
                div_q <= is_div;
                count <= '0;
                acc   <= '0;
                mq    <= is_div ? a : b;
                opd   <= is_div ? b : a;
            end else if (run) begin
                count <= count + CW'(1);
                if (div_q) begin
                    if (!sum[W]) begin
                        acc <= sum[W-1:0];
                        mq  <= {mq[W-2:0], 1'b1};
                    end else begin
                        acc <= x[W-1:0];
                        mq  <= {mq[W-2:0], 1'b0};
                    end
                end else begin
                    acc <= sum[W-1:0];
                    mq  <= mq >> 1;
                    opd <= opd << 1;
                end
                if (count == CW'(W - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign result = div_q ? mq : acc;

endmodule

// File: rtl/stage_ex_mc.sv
// Multi-cycle execute stage: combinational ALU plus an iterative
// MUL/DIV unit, with valid/ready on both the ID and MEM sides.
module stage_ex_mc
    import stage_ex_mc_pkg::*;
#(
    parameter int W   = 32,
    parameter int SHW = $clog2(W)
) (
    input logic         clk,
    input logic         rst,
    stage_ex_mc_if.slave bus
);
    logic [0:0]     state;
    logic           accept;
    logic           take_md;
    logic           md_done;
    logic [W-1:0]   md_res;
    logic [4:0]     md_rw;
    logic [W-1:0]   bv;
    logic [SHW-1:0] shamt;
    logic [W-1:0]   alu;
    logic [W-1:0]   link;
    logic           ov_q;
    logic [W-1:0]   ans_q;
    logic [4:0]     rw_q;

    assign bus.in_ready = (state == IDLE) && (!ov_q || bus.out_ready);
    assign accept  = bus.in_valid && bus.in_ready && !bus.flush;
    assign take_md = accept && is_md(bus.op) && !bus.jal;
    assign bus.busy      = (state == BUSY);
    assign bus.out_valid = ov_q;
    assign bus.ans       = ans_q;
    assign bus.rw        = rw_q;

    assign bv    = bus.aluimm ? bus.imm : bus.b;
    assign shamt = bus.shift ? bus.imm[SHW+5:6] : bus.a[SHW-1:0];
    assign link  = bus.pc4 + W'(4);

    always_comb begin
        alu = bus.a;
        unique case (1'b1)
            bus.op == OP_ADD: alu = bus.a + bv;
            bus.op == OP_SUB: alu = bus.a - bv;
            bus.op == OP_AND: alu = bus.a & bv;
            bus.op == OP_OR:  alu = bus.a | bv;
            bus.op == OP_XOR: alu = bus.a ^ bv;
            bus.op == OP_LUI: alu = bv << (W / 2);
            bus.op == OP_SLL: alu = bv << shamt;
            bus.op == OP_SRL: alu = bv >> shamt;
            bus.op == OP_SRA: alu = $signed(bv) >>> shamt;
            default:          alu = bus.a;
        endcase
    end

    stage_ex_mc_mdu #(.W(W)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .kill   (bus.flush),
        .start  (take_md),
        .is_div (bus.op == OP_DIV),
        .a      (bus.a),
        .b      (bv),
        .done   (md_done),
        .result (md_res)
    );

    // a new result may load on the same edge the old one is consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ov_q  <= 1'b0;
            ans_q <= '0;
            rw_q  <= '0;
            md_rw <= '0;
        end else if (bus.flush) begin
            state <= IDLE;
            ov_q  <= 1'b0;
        end else begin
            if (accept && !take_md) begin
                ov_q  <= 1'b1;
                ans_q <= bus.jal ? link : alu;
                rw_q  <= bus.jal ? RA : bus.rw_in;
            end else if (state == BUSY && md_done) begin
                ov_q  <= 1'b1;
                ans_q <= md_res;
                rw_q  <= md_rw;
            end else if (ov_q && bus.out_ready) begin
                ov_q <= 1'b0;
            end
            if (take_md) begin
                state <= BUSY;
                md_rw <= bus.rw_in;
            end else if (state == BUSY && md_done) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_stage_ex_mc.sv
// Directed bench for stage_ex_mc: ALU ops, MUL/DIV latency,
// back-pressure, jal, flush and asynchronous reset.
module tb_stage_ex_mc;
    import stage_ex_mc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    stage_ex_mc_if #(.W(32)) bus ();

    stage_ex_mc #(.W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: no finish by %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic aluimm,
                         input logic shift, input logic jal,
                         input logic [31:0] pc4, input logic [4:0] rwi);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.imm = imm;
        bus.aluimm = aluimm;
        bus.shift = shift;
        bus.jal = jal;
        bus.pc4 = pc4;
        bus.rw_in = rwi;
    endtask

    task automatic alu1(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
        drive(op, a, b, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd2);
        step();
        bus.in_valid = 1'b0;
        chk(tag, bus.ans, exp);
    endtask

    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int   k;
        logic bad;
        drive(op, a, b, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd7);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, bus.busy, 1);
        k = 0;
        bad = 1'b0;
        while (!bus.out_valid && k < 100) begin
            if (bus.in_ready) bad = 1'b1;
            step();
            k++;
        end
        chk({tag, "_lat"}, k, 33);
        chk({tag, "_stall"}, bad, 0);
        chk({tag, "_ans"}, bus.ans, exp);
        chk({tag, "_rw"}, bus.rw, 7);
        chk({tag, "_idle"}, bus.busy, 0);
        step();
    endtask

    initial begin
        int   k;
        logic seen;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_ov", bus.out_valid, 0);
        chk("rst_ans", bus.ans, 0);
        chk("rst_rw", bus.rw, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rdy", bus.in_ready, 1);
        step();
        step();
        rst = 1'b0;

        drive(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 0, 5'd5);
        #1 chk("add_rdy", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("add_ov", bus.out_valid, 1);
        chk("add_wrap", bus.ans, 32'h0);
        chk("add_rw", bus.rw, 5);

        drive(OP_SRA, 0, 32'h8000_0000, 32'h100, 0, 1, 0, 0, 5'd6);
        step();
        chk("sra", bus.ans, 32'hF800_0000);
        drive(OP_SRL, 0, 32'h8000_0000, 32'h100, 0, 1, 0, 0, 5'd6);
        step();
        chk("srl", bus.ans, 32'h0800_0000);
        drive(OP_LUI, 0, 0, 32'h0000_1234, 1, 0, 0, 0, 5'd8);
        step();
        bus.in_valid = 1'b0;
        chk("lui", bus.ans, 32'h1234_0000);
        chk("b2b_ov", bus.out_valid, 1);
        chk("lui_rw", bus.rw, 8);

        alu1("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu1("and", OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F,
             32'h00F0_000F);
        alu1("or", OP_OR, 32'hF0F0_00FF, 32'h0FF0_0F0F,
             32'hFFF0_0FFF);
        alu1("xor", OP_XOR, 32'hF0F0_00FF, 32'h0FF0_0F0F,
             32'hFF00_0FF0);
        alu1("sll_a", OP_SLL, 32'd4, 32'd3, 32'h30);
        alu1("sra31", OP_SRA, 32'd31, 32'h8000_0000, 32'hFFFF_FFFF);
        alu1("dflt", 4'b0011, 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF);

        run_md("mul", OP_MUL, 32'd7, 32'd6, 32'd42);
        run_md("div", OP_DIV, 32'd100, 32'd7, 32'd14);
        run_md("div0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_md("mulw", OP_MUL, 32'h0001_0000, 32'h0001_0001,
               32'h0001_0000);
        run_md("divb", OP_DIV, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

        bus.out_ready = 1'b0;
        drive(OP_ADD, 32'd3, 32'd4, 0, 0, 0, 0, 0, 5'd9);
        step();
        drive(OP_ADD, 32'd1, 32'd1, 0, 0, 0, 0, 0, 5'd10);
        for (int i = 0; i < 5; i++) begin
            chk("hold_ov", bus.out_valid, 1);
            chk("hold_ans", bus.ans, 7);
            chk("hold_rw", bus.rw, 9);
            chk("hold_rdy", bus.in_ready, 0);
            step();
        end
        bus.out_ready = 1'b1;
        #1 chk("rel_rdy", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        chk("rel_ov", bus.out_valid, 1);
        chk("rel_ans", bus.ans, 2);
        chk("rel_rw", bus.rw, 10);

        drive(OP_MUL, 5, 6, 0, 0, 0, 1, 32'h0040_0004, 5'd3);
        step();
        bus.in_valid = 1'b0;
        chk("jal_ov", bus.out_valid, 1);
        chk("jal_ans", bus.ans, 32'h0040_0008);
        chk("jal_rw", bus.rw, 31);
        chk("jal_busy", bus.busy, 0);

        drive(OP_MUL, 7, 6, 0, 0, 0, 0, 0, 5'd7);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        chk("fl_pre", bus.busy, 1);
        bus.flush = 1'b1;
        drive(OP_ADD, 1, 1, 0, 0, 0, 0, 0, 5'd1);
        step();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_ov", bus.out_valid, 0);
        chk("fl_busy", bus.busy, 0);
        chk("fl_rdy", bus.in_ready, 1);
        seen = 1'b0;
        for (k = 0; k < 40; k++) begin
            if (bus.out_valid) seen = 1'b1;
            step();
        end
        chk("fl_quiet", seen, 0);

        alu1("pre_rst", OP_ADD, 32'd1, 32'd2, 32'd3);
        drive(OP_MUL, 7, 6, 0, 0, 0, 0, 0, 5'd7);
        step();
        bus.in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        #1;
        chk("ar_ov", bus.out_valid, 0);
        chk("ar_ans", bus.ans, 0);
        chk("ar_rw", bus.rw, 0);
        chk("ar_busy", bus.busy, 0);
        step();
        rst = 1'b0;
        alu1("post_rst", OP_ADD, 32'd2, 32'd3, 32'd5);
        chk("post_ov", bus.out_valid, 1);
        chk("post_rw", bus.rw, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
